bus_mem_responder: RTL and testbench
====================================

Name: bus_mem_responder

Overview:
- Slave-side responder for the 8085-style multiplexed bus driven by the team's CPU core.
- Demultiplexes the address: high byte on the ADD pins, low byte on the shared DATA/AD pins, qualified by ALE.
- Decodes a memory window and one I/O port. Serves reads onto AD and captures writes from AD.
- Drives READY with a programmable number of wait states, and counts completed opcode fetches for debug.

Parameters:
- ADDR_WIDTH, 8: internal RAM depth is 2**ADDR_WIDTH bytes.
- MEM_BASE, 16'h0100: base of the memory window; bits [ADDR_WIDTH-1:0] must be 0.
- WAIT_STATES, 0: READY-low cycles inserted per selected access (0..15).
- IO_PORT, 8'h10: I/O address of port_out/port_in.

Ports:
- clock  in  1  single clock; all sequential logic on posedge.
- reset_in  in  1  asynchronous, active-high reset.
- AD  inout  8  multiplexed low address / data (the CPU's DATA pins).
- A_HI  in  8  high address byte (the CPU's ADD pins).
- ALE  in  1  address latch enable.
- RDn  in  1  read strobe, active low.
- WRn  in  1  write strobe, active low.
- IO_Mn  in  1  1 = I/O cycle, 0 = memory cycle.
- S0, S1  in  1 each  bus status; S1=S0=1 marks an opcode fetch.
- READY  out  1  wait request to the CPU; 0 = hold.
- port_in  in  8  value returned on I/O read of IO_PORT.
- port_out  out  8  register written by I/O write to IO_PORT.
- fetch_count  out  16  number of completed opcode-fetch reads that hit this block.
- bus_err  out  1  one-cycle pulse when RDn and WRn are sampled low together.

Behaviour:
- Reset (asynchronous) sets:
  - state = IDLE, READY = 1, AD = Z, port_out = 8'h00, fetch_count = 0, bus_err = 0.
  - Latched address and status cleared. RAM contents are not cleared.
- Address latch: on each posedge with ALE=1:
  - addr <= {A_HI, AD}; io <= IO_Mn; fetch <= S1&S0; state -> ADDR.
  - This applies from any state, so a new ALE aborts any cycle in progress; an aborted write never commits.
- Select (evaluated on the latched values):
  - mem_sel = !io && addr[15:ADDR_WIDTH] == MEM_BASE[15:ADDR_WIDTH].
  - io_sel = io && addr[7:0] == IO_PORT.
  - sel = mem_sel | io_sel.
- State machine:
  - IDLE: wait for ALE.
  - ADDR:
    - !sel → IDLE (no AD drive, READY stays 1).
    - RDn=0 & WRn=1 → RWAIT, loading wcnt = WAIT_STATES.
    - WRn=0 & RDn=1 → WWAIT, loading wcnt = WAIT_STATES.
    - RDn=0 & WRn=0 → bus_err pulse, go to IDLE.
  - RWAIT:
    - READY = 0 while wcnt != 0; wcnt decrements each cycle.
    - When wcnt == 0: rdata <= mem_sel ? ram[addr[ADDR_WIDTH-1:0]] : port_in; → RDATA.
    - With WAIT_STATES=0 this is one cycle and READY never falls.
  - RDATA:
    - AD driven with rdata while RDn=0; READY = 1.
    - On RDn sampled 1 → IDLE. If fetch is set, fetch_count increments (wraps 16'hFFFF→0).
  - WWAIT:
    - Same wait counting as RWAIT.
    - When wcnt == 0 and WRn=0: write AD into ram[addr[ADDR_WIDTH-1:0]], or into port_out when io_sel. Exactly one write; → WDONE.
    - WRn rising before wcnt reaches 0 → IDLE, no write.
  - WDONE: on WRn sampled 1 → IDLE. Holding WRn low never produces a second write.
- READY is 0 only in RWAIT/WWAIT with wcnt != 0; it is 1 in every other state.
- AD output enable = (state == RDATA) && !RDn && !ALE. In all other cases AD is Z; this block never drives AD during ALE.
- Address arithmetic wraps within ADDR_WIDTH bits. The I/O decode ignores A_HI.

Test Plan:
- MEM_BASE=16'h0100, WAIT_STATES=0; memory write 8'h5A to 16'h0123, then read of 16'h0123 → AD=8'h5A while RDn low; READY stays 1 throughout.
- WAIT_STATES=3; read of 16'h0100 → READY low for exactly 3 clocks after RDn falls; AD driven only after READY rises.
- Opcode fetch (S1=S0=1) of 16'h0100, then a plain read (S1=1, S0=0) → fetch_count goes 0→1 and stays 1.
- I/O write 8'hC3 to port 8'h10 → port_out=8'hC3; I/O read with port_in=8'h7E → AD=8'h7E. A memory-mapped access to 16'h0010 is not selected → AD stays Z.
- Read of 16'h0200 (outside the window) → AD Z, READY 1. RDn=WRn=0 on a selected cycle → bus_err single pulse and no RAM change.
- reset_in asserted mid-read with WAIT_STATES=5 → READY=1 and AD=Z immediately; the previously written 8'h5A at 16'h0123 is still readable after reset.

Source files
------------

// File: rtl/bus_mem_responder.sv
// Slave responder for the multiplexed 8085-style bus: address demux, one memory window,
// one I/O port, programmable wait states and a debug counter of opcode fetches.
//
// state | meaning
// IDLE  | no cycle for this block; waiting for ALE
// ADDR  | address latched, waiting for a read or write strobe
// RWAIT | read wait states; rdata captured when wcnt reaches 0
// RDATA | rdata driven on AD while RDn is low
// WWAIT | write wait states; write commits when wcnt reaches 0
// WDONE | write committed, waiting for WRn to rise
module bus_mem_responder #(
   parameter int          ADDR_WIDTH  = 8,
   parameter logic [15:0] MEM_BASE    = 16'h0100,
   parameter int          WAIT_STATES = 0,
   parameter logic [7:0]  IO_PORT     = 8'h10
) (
   input  logic        clock,
   input  logic        reset_in,
   inout  wire  [7:0]  AD,
   input  logic [7:0]  A_HI,
   input  logic        ALE,
   input  logic        RDn,
   input  logic        WRn,
   input  logic        IO_Mn,
   input  logic        S0,
   input  logic        S1,
   output logic        READY,
   input  logic [7:0]  port_in,
   output logic [7:0]  port_out,
   output logic [15:0] fetch_count,
   output logic        bus_err
);

   typedef enum logic [2:0] {IDLE, ADDR, RWAIT, RDATA, WWAIT, WDONE} state_t;

   localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

   state_t      state, state_nxt;
   logic [3:0]  wcnt, wcnt_nxt;
   logic [15:0] addr;
   logic        io, fetch;
   logic [7:0]  rdata;
   logic        mem_sel, io_sel, sel;
   logic        rdata_ld, ram_we, port_we, fetch_inc, err_set;
   logic        ad_oe;

   logic [7:0]  ram [2**ADDR_WIDTH];

   assign mem_sel = !io && (addr[15:ADDR_WIDTH] == MEM_BASE[15:ADDR_WIDTH]);
   assign io_sel  = io && (addr[7:0] == IO_PORT);
   assign sel     = mem_sel | io_sel;

   always_ff @(posedge clock or posedge reset_in) begin
      if (reset_in) state <= IDLE;
      else          state <= state_nxt;
   end

   // ALE has priority over every state so a new address aborts any cycle in flight.
   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      rdata_ld  = 1'b0;
      ram_we    = 1'b0;
      port_we   = 1'b0;
      fetch_inc = 1'b0;
      err_set   = 1'b0;
      if (ALE) begin
         state_nxt = ADDR;
      end else begin
         case (state)
            IDLE: state_nxt = IDLE;
            ADDR: begin
               if (!sel) begin
                  state_nxt = IDLE;
               end else if (!RDn && !WRn) begin
                  err_set   = 1'b1;
                  state_nxt = IDLE;
               end else if (!RDn) begin
                  state_nxt = RWAIT;
                  wcnt_nxt  = WAIT_LD;
               end else if (!WRn) begin
                  state_nxt = WWAIT;
                  wcnt_nxt  = WAIT_LD;
               end
            end
            RWAIT: begin
               if (wcnt != 4'd0) begin
                  wcnt_nxt = wcnt - 4'd1;
               end else begin
                  rdata_ld  = 1'b1;
                  state_nxt = RDATA;
               end
            end
            RDATA: begin
               if (RDn) begin
                  fetch_inc = fetch;
                  state_nxt = IDLE;
               end
            end
            WWAIT: begin
               if (WRn) begin
                  state_nxt = IDLE;
               end else if (wcnt != 4'd0) begin
                  wcnt_nxt = wcnt - 4'd1;
               end else begin
                  ram_we    = mem_sel;
                  port_we   = io_sel;
                  state_nxt = WDONE;
               end
            end
            WDONE: begin
               if (WRn) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset_in) begin
      if (reset_in) begin
         addr        <= 16'h0000;
         io          <= 1'b0;
         fetch       <= 1'b0;
         wcnt        <= 4'd0;
         rdata       <= 8'h00;
         port_out    <= 8'h00;
         fetch_count <= 16'h0000;
         bus_err     <= 1'b0;
      end else begin
         if (ALE) begin
            addr  <= {A_HI, AD};
            io    <= IO_Mn;
            fetch <= S1 & S0;
         end
         wcnt <= wcnt_nxt;
         if (rdata_ld)  rdata       <= mem_sel ? ram[addr[ADDR_WIDTH-1:0]] : port_in;
         if (port_we)   port_out    <= AD;
         if (fetch_inc) fetch_count <= fetch_count + 16'd1;
         bus_err <= err_set;
      end
   end

   // RAM has no reset so its contents survive reset_in.
   always_ff @(posedge clock) begin
      if (ram_we) ram[addr[ADDR_WIDTH-1:0]] <= AD;
   end

   assign READY = !(((state == RWAIT) || (state == WWAIT)) && (wcnt != 4'd0));
   assign ad_oe = (state == RDATA) && !RDn && !ALE;
   assign AD    = ad_oe ? rdata : 8'hzz;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench: three responders (0, 3 and 5 wait states) share one bus; a released
// AD reads back as 8'hFF through the pull-up nets.
module tb_bus_mem_responder;

   logic       clock = 1'b0;
   logic       reset_in;
   logic [7:0] A_HI, port_in, ad_drv;
   logic       ALE, RDn, WRn, IO_Mn, S0, S1, ad_drv_en;

   always #5 clock = ~clock;

   tri1 [7:0] ad0, ad1, ad2;
   assign ad0 = ad_drv_en ? ad_drv : 8'hzz;
   assign ad1 = ad_drv_en ? ad_drv : 8'hzz;
   assign ad2 = ad_drv_en ? ad_drv : 8'hzz;

   wire        rdy0, rdy1, rdy2, be0, be1, be2;
   wire [7:0]  po0, po1, po2;
   wire [15:0] fc0, fc1, fc2;

   bus_mem_responder #(.WAIT_STATES(0)) u_w0 (
      .clock(clock), .reset_in(reset_in), .AD(ad0), .A_HI(A_HI), .ALE(ALE), .RDn(RDn),
      .WRn(WRn), .IO_Mn(IO_Mn), .S0(S0), .S1(S1), .READY(rdy0), .port_in(port_in),
      .port_out(po0), .fetch_count(fc0), .bus_err(be0));
   bus_mem_responder #(.WAIT_STATES(3)) u_w3 (
      .clock(clock), .reset_in(reset_in), .AD(ad1), .A_HI(A_HI), .ALE(ALE), .RDn(RDn),
      .WRn(WRn), .IO_Mn(IO_Mn), .S0(S0), .S1(S1), .READY(rdy1), .port_in(port_in),
      .port_out(po1), .fetch_count(fc1), .bus_err(be1));
   bus_mem_responder #(.WAIT_STATES(5)) u_w5 (
      .clock(clock), .reset_in(reset_in), .AD(ad2), .A_HI(A_HI), .ALE(ALE), .RDn(RDn),
      .WRn(WRn), .IO_Mn(IO_Mn), .S0(S0), .S1(S1), .READY(rdy2), .port_in(port_in),
      .port_out(po2), .fetch_count(fc2), .bus_err(be2));

   localparam int WS [3] = '{0, 3, 5};

   wire [7:0]  ad_s [3];
   wire        ready_s [3];
   wire        be_s [3];
   wire [7:0]  po_s [3];
   wire [15:0] fc_s [3];
   assign ad_s[0] = ad0;   assign ad_s[1] = ad1;   assign ad_s[2] = ad2;
   assign ready_s[0] = rdy0; assign ready_s[1] = rdy1; assign ready_s[2] = rdy2;
   assign be_s[0] = be0;   assign be_s[1] = be1;   assign be_s[2] = be2;
   assign po_s[0] = po0;   assign po_s[1] = po1;   assign po_s[2] = po2;
   assign fc_s[0] = fc0;   assign fc_s[1] = fc1;   assign fc_s[2] = fc2;

   typedef struct packed {
      logic [7:0] ad;
      logic [3:0] lo0;
      logic [3:0] lo1;
      logic [3:0] lo2;
   } exp_t;

   exp_t exp_q [$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input int idx, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] ad, input logic [3:0] l0, input logic [3:0] l1,
                           input logic [3:0] l2);
      exp_t e;
      e.ad = ad; e.lo0 = l0; e.lo1 = l1; e.lo2 = l2;
      exp_q.push_back(e);
   endtask

   // Selected reads expect the full wait-state count; unselected reads see no wait.
   task automatic push_read(input logic [7:0] ad, input logic sel);
      if (sel) push_exp(ad, 4'(WS[0]), 4'(WS[1]), 4'(WS[2]));
      else     push_exp(ad, 4'd0, 4'd0, 4'd0);
   endtask

   // Monitor: sample AD/READY while RDn is low, compare when the read strobe ends.
   initial begin
      int         lo_cnt [3];
      logic [7:0] last_ad [3];
      logic       rdn_prev;
      exp_t       e;
      int         lo_exp;
      rdn_prev = 1'b1;
      for (int i = 0; i < 3; i++) begin lo_cnt[i] = 0; last_ad[i] = 8'hFF; end
      forever begin
         @(negedge clock);
         if (RDn === 1'b0) begin
            for (int i = 0; i < 3; i++) begin
               last_ad[i] = ad_s[i];
               if (!ready_s[i]) begin
                  lo_cnt[i]++;
                  check("ad_released_during_wait", i, int'(ad_s[i]), 8'hFF);
               end
            end
         end else if (!rdn_prev) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL scoreboard_underflow: read ended with no expectation queued");
            end else begin
               e = exp_q.pop_front();
               for (int i = 0; i < 3; i++) begin
                  lo_exp = (i == 0) ? int'(e.lo0) : (i == 1) ? int'(e.lo1) : int'(e.lo2);
                  check("read_data", i, int'(last_ad[i]), int'(e.ad));
                  check("ready_low_cycles", i, lo_cnt[i], lo_exp);
               end
            end
            for (int i = 0; i < 3; i++) lo_cnt[i] = 0;
         end
         rdn_prev = (RDn === 1'b0) ? 1'b0 : 1'b1;
      end
   end

   task automatic addr_phase(input logic [15:0] a, input logic io, input logic s1,
                             input logic s0);
      @(posedge clock); #1;
      ALE = 1'b1; A_HI = a[15:8]; ad_drv = a[7:0]; ad_drv_en = 1'b1;
      IO_Mn = io; S1 = s1; S0 = s0;
      @(posedge clock); #1;
      ALE = 1'b0; ad_drv_en = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] a, input logic io, input logic s1,
                           input logic s0, input logic [7:0] exp_ad, input logic sel);
      addr_phase(a, io, s1, s0);
      RDn = 1'b0;
      push_read(exp_ad, sel);
      repeat (10) @(posedge clock);
      #1 RDn = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic io, input logic [7:0] d);
      addr_phase(a, io, 1'b0, 1'b0);
      WRn = 1'b0; ad_drv = d; ad_drv_en = 1'b1;
      repeat (10) @(posedge clock);
      #1 WRn = 1'b1; ad_drv_en = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic check_all(input string name, input int sel_sig, input int exp);
      for (int i = 0; i < 3; i++) begin
         case (sel_sig)
            0: check(name, i, int'(ready_s[i]), exp);
            1: check(name, i, int'(ad_s[i]), exp);
            2: check(name, i, int'(po_s[i]), exp);
            3: check(name, i, int'(fc_s[i]), exp);
            default: check(name, i, int'(be_s[i]), exp);
         endcase
      end
   endtask

   initial begin
      int pulses [3];
      reset_in = 1'b1; ALE = 1'b0; RDn = 1'b1; WRn = 1'b1; IO_Mn = 1'b0;
      S0 = 1'b0; S1 = 1'b0; A_HI = 8'h00; port_in = 8'h7E; ad_drv = 8'h00; ad_drv_en = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_all("reset_ready", 0, 1);
      check_all("reset_ad_released", 1, 8'hFF);
      check_all("reset_port_out", 2, 8'h00);
      check_all("reset_fetch_count", 3, 0);
      check_all("reset_bus_err", 4, 0);
      reset_in = 1'b0;

      bus_write(16'h0123, 1'b0, 8'h5A);
      bus_read (16'h0123, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1);
      bus_write(16'h0100, 1'b0, 8'h3C);
      bus_read (16'h0100, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1);
      bus_write(16'h01FF, 1'b0, 8'hA5);
      bus_read (16'h01FF, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1);

      bus_read (16'h0100, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1);
      check_all("fetch_count_after_fetch", 3, 1);
      bus_read (16'h0100, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1);
      check_all("fetch_count_after_plain_read", 3, 1);
      bus_read (16'h0200, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0);
      check_all("fetch_count_after_unselected_fetch", 3, 1);

      bus_write(16'h0010, 1'b1, 8'hC3);
      check_all("port_out_after_io_write", 2, 8'hC3);
      bus_read (16'h5510, 1'b1, 1'b0, 1'b0, 8'h7E, 1'b1);
      bus_read (16'h0011, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
      bus_read (16'h0010, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);
      bus_write(16'h0010, 1'b0, 8'h99);
      check_all("port_out_after_mem_write_0010", 2, 8'hC3);
      bus_read (16'h0200, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);

      // Both strobes low on a selected cycle.
      addr_phase(16'h0123, 1'b0, 1'b0, 1'b0);
      RDn = 1'b0; WRn = 1'b0;
      push_read(8'hFF, 1'b0);
      for (int i = 0; i < 3; i++) pulses[i] = 0;
      repeat (4) begin
         @(negedge clock);
         for (int i = 0; i < 3; i++) if (be_s[i]) pulses[i]++;
      end
      @(posedge clock); #1;
      RDn = 1'b1; WRn = 1'b1;
      @(posedge clock); #1;
      for (int i = 0; i < 3; i++) check("bus_err_pulse_count", i, pulses[i], 1);
      bus_read (16'h0123, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1);

      // Reset in the middle of a read: two wait cycles seen by the 3- and 5-wait parts.
      addr_phase(16'h0123, 1'b0, 1'b0, 1'b0);
      RDn = 1'b0;
      push_exp(8'hFF, 4'd0, 4'd2, 4'd2);
      repeat (3) @(negedge clock);
      #2 reset_in = 1'b1;
      #1;
      check_all("ready_on_reset", 0, 1);
      check_all("ad_released_on_reset", 1, 8'hFF);
      @(posedge clock); #1;
      reset_in = 1'b0;
      @(posedge clock); #1;
      RDn = 1'b1;
      @(posedge clock); #1;
      check_all("port_out_after_reset", 2, 8'h00);
      check_all("fetch_count_after_reset", 3, 0);
      bus_read (16'h0123, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1);

      repeat (3) @(posedge clock);
      check("scoreboard_drained", 0, exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
